// File: rtl/cluster_pkg.sv
// Shared types and helpers for the first_n_of_m cluster selector.
// cluster_t is sized for the widest supported address/count fields.
package cluster_pkg;

  localparam int LATCH_DEPTH = 16;
  localparam int CL_ADR_W    = 16;
  localparam int CL_CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    MERGE,
    DONE
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [CL_ADR_W-1:0] adr;
    logic [CL_CNT_W-1:0] cnt;
  } cluster_t;

  function automatic logic [CL_ADR_W-1:0] invalid_adr(input int bits);
    return CL_ADR_W'((32'd1 << bits) - 32'd1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iter_encoder.sv
// One partition of first_n_of_m: holds a working copy of the flags,
// peels off the lowest set bit per step and records it in a list.
// Ports: clk, rst (sync), load (capture vpfs/cnts), step (encode one),
//   slot (list index), residual (flags left), list_vld/adr/cnt (list).
module iter_encoder
  import cluster_pkg::*;
#(
  parameter int PART_WIDTH   = 768,
  parameter int MAX_CLUSTERS = 8,
  parameter int ADR_BITS     = 11,
  parameter int CNT_BITS     = 3,
  parameter int BASE         = 0,
  parameter int SW           = idx_w(MAX_CLUSTERS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic                             step,
  input  logic [PART_WIDTH-1:0]            vpfs,
  input  logic [PART_WIDTH*CNT_BITS-1:0]   cnts,
  input  logic [SW-1:0]                    slot,
  output logic                             residual,
  output logic [MAX_CLUSTERS-1:0]          list_vld,
  output logic [MAX_CLUSTERS*ADR_BITS-1:0] list_adr,
  output logic [MAX_CLUSTERS*CNT_BITS-1:0] list_cnt
);

  localparam int IW = idx_w(PART_WIDTH);
  localparam logic [CL_ADR_W-1:0] INV_FULL = invalid_adr(ADR_BITS);
  localparam logic [ADR_BITS-1:0] INV = INV_FULL[ADR_BITS-1:0];

  logic [PART_WIDTH-1:0]          work;
  logic [PART_WIDTH*CNT_BITS-1:0] cnts_q;
  logic                           hit;
  logic [IW-1:0]                  low;
  logic [CNT_BITS-1:0]            cnt_sel;
  logic [ADR_BITS-1:0]            adr_sel;

  // Scanning downward leaves the lowest set bit as the final winner.
  always_comb begin
    hit     = 1'b0;
    low     = '0;
    cnt_sel = '0;
    for (int i = PART_WIDTH - 1; i >= 0; i--) begin
      if (work[i]) begin
        hit     = 1'b1;
        low     = IW'(i);
        cnt_sel = cnts_q[i*CNT_BITS +: CNT_BITS];
      end
    end
  end

  assign adr_sel  = ADR_BITS'(BASE) + ADR_BITS'(low);
  assign residual = |work;

  always_ff @(posedge clk) begin
    if (rst) begin
      work     <= '0;
      cnts_q   <= '0;
      list_vld <= '0;
      list_adr <= {MAX_CLUSTERS{INV}};
      list_cnt <= '0;
    end else if (load) begin
      work     <= vpfs;
      cnts_q   <= cnts;
      list_vld <= '0;
      list_adr <= {MAX_CLUSTERS{INV}};
      list_cnt <= '0;
    end else if (step) begin
      list_vld[slot] <= hit;
      if (hit) begin
        list_adr[slot*ADR_BITS +: ADR_BITS] <= adr_sel;
        list_cnt[slot*CNT_BITS +: CNT_BITS] <= cnt_sel;
        work <= work & ~(PART_WIDTH'(1) << low);
      end
    end
  end

endmodule

// File: rtl/first_n_of_m.sv
// Frame-based selector: first MAX_CLUSTERS clusters in strip order.
// Optional FIRST_N_OVERFLOW_COUNTER_EN adds saturating overflow_count.
// Ports: clock4x, global_reset (sync), latch_in, latch_delay,
//   vpfs_in, cnts_in -> adr_out, cnt_out, vpf_out, frame_valid,
//   overflow, busy, dropped [, overflow_count].
module first_n_of_m
  import cluster_pkg::*;
#(
  parameter int NUM_PARTS    = 2,
  parameter int PART_WIDTH   = 768,
  parameter int MAX_CLUSTERS = 8,
  parameter int CNT_BITS     = 3,
  parameter int ADR_BITS     = 11
) (
  input  logic                                  clock4x,
  input  logic                                  global_reset,
  input  logic                                  latch_in,
  input  logic [3:0]                            latch_delay,
  input  logic [NUM_PARTS*PART_WIDTH-1:0]       vpfs_in,
  input  logic [NUM_PARTS*PART_WIDTH*CNT_BITS-1:0] cnts_in,
  output logic [MAX_CLUSTERS*ADR_BITS-1:0]      adr_out,
  output logic [MAX_CLUSTERS*CNT_BITS-1:0]      cnt_out,
  output logic [MAX_CLUSTERS-1:0]               vpf_out,
  output logic                                  frame_valid,
  output logic                                  overflow,
`ifdef FIRST_N_OVERFLOW_COUNTER_EN
  output logic [15:0]                           overflow_count,
`endif
  output logic                                  busy,
  output logic                                  dropped
);

  localparam int M    = MAX_CLUSTERS;
  localparam int NC   = NUM_PARTS * MAX_CLUSTERS;
  localparam int SW   = idx_w(M);
  localparam int CW   = (idx_w(NC) > SW) ? idx_w(NC) : SW;
  localparam int FW   = idx_w(M + 1);
  localparam int PW   = PART_WIDTH;
  localparam logic [CL_ADR_W-1:0] INV_FULL = invalid_adr(ADR_BITS);
  localparam logic [ADR_BITS-1:0] INV = INV_FULL[ADR_BITS-1:0];

  state_e                     state;
  logic [LATCH_DEPTH-1:0]     latch_sr;
  logic                       latch_dly;
  logic                       capture;
  logic                       enc_step;
  logic [CW-1:0]              step_cnt;
  logic [FW-1:0]              fill;
  logic                       ovf_pending;
  logic [NUM_PARTS-1:0]       residual;
  logic [NC-1:0]              cand_vld;
  logic [NC*ADR_BITS-1:0]     cand_adr;
  logic [NC*CNT_BITS-1:0]     cand_cnt;
  cluster_t                   slots [M];

  always_ff @(posedge clock4x) begin
    if (global_reset) latch_sr <= '0;
    else latch_sr <= {latch_sr[LATCH_DEPTH-2:0], latch_in};
  end

  // Tap 0 already carries one cycle of delay.
  assign latch_dly = latch_sr[latch_delay];
  assign capture   = (state == IDLE) && latch_dly;
  assign enc_step  = (state == ENCODE);
  assign busy      = (state != IDLE);

  for (genvar p = 0; p < NUM_PARTS; p++) begin : g_part
    iter_encoder #(
      .PART_WIDTH  (PW),
      .MAX_CLUSTERS(M),
      .ADR_BITS    (ADR_BITS),
      .CNT_BITS    (CNT_BITS),
      .BASE        (p * PW),
      .SW          (SW)
    ) u_enc (
      .clk     (clock4x),
      .rst     (global_reset),
      .load    (capture),
      .step    (enc_step),
      .vpfs    (vpfs_in[p*PW +: PW]),
      .cnts    (cnts_in[p*PW*CNT_BITS +: PW*CNT_BITS]),
      .slot    (step_cnt[SW-1:0]),
      .residual(residual[p]),
      .list_vld(cand_vld[p*M +: M]),
      .list_adr(cand_adr[p*M*ADR_BITS +: M*ADR_BITS]),
      .list_cnt(cand_cnt[p*M*CNT_BITS +: M*CNT_BITS])
    );
  end

  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      state       <= IDLE;
      step_cnt    <= '0;
      fill        <= '0;
      ovf_pending <= 1'b0;
      dropped     <= 1'b0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
      vpf_out     <= '0;
      cnt_out     <= '0;
      adr_out     <= {M{INV}};
      for (int i = 0; i < M; i++) begin
        slots[i] <= '{valid: 1'b0, adr: INV_FULL, cnt: '0};
      end
    end else begin
      frame_valid <= 1'b0;
      dropped     <= latch_dly && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (latch_dly) begin
            state       <= ENCODE;
            step_cnt    <= '0;
            fill        <= '0;
            ovf_pending <= 1'b0;
            for (int i = 0; i < M; i++) begin
              slots[i] <= '{valid: 1'b0, adr: INV_FULL, cnt: '0};
            end
          end
        end
        ENCODE: begin
          if (step_cnt == CW'(M - 1)) begin
            state    <= MERGE;
            step_cnt <= '0;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        MERGE: begin
          // Leftover flags after M encode steps mean clusters were lost.
          if (|residual) ovf_pending <= 1'b1;
          if (cand_vld[step_cnt]) begin
            if (fill < FW'(M)) begin
              slots[fill[SW-1:0]] <= '{
                valid: 1'b1,
                adr:   CL_ADR_W'(cand_adr[step_cnt*ADR_BITS +: ADR_BITS]),
                cnt:   CL_CNT_W'(cand_cnt[step_cnt*CNT_BITS +: CNT_BITS])
              };
              fill <= fill + 1'b1;
            end else begin
              ovf_pending <= 1'b1;
            end
          end
          if (step_cnt == CW'(NC - 1)) begin
            state    <= DONE;
            step_cnt <= '0;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        DONE: begin
          for (int i = 0; i < M; i++) begin
            adr_out[i*ADR_BITS +: ADR_BITS] <= slots[i].adr[ADR_BITS-1:0];
            cnt_out[i*CNT_BITS +: CNT_BITS] <= slots[i].cnt[CNT_BITS-1:0];
            vpf_out[i] <= slots[i].valid;
          end
          overflow    <= ovf_pending;
          frame_valid <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIRST_N_OVERFLOW_COUNTER_EN
  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      overflow_count <= '0;
    end else if (state == DONE && ovf_pending
                 && overflow_count != 16'hFFFF) begin
      overflow_count <= overflow_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_first_n_of_m.sv
// Directed bench for first_n_of_m with default parameters.
// Checks latency, slot contents, overflow, drop and reset handling.
module tb_first_n_of_m;

  localparam int NW = 1536;
  localparam int M  = 8;

  logic            clock4x = 1'b0;
  logic            global_reset;
  logic            latch_in;
  logic [3:0]      latch_delay;
  logic [NW-1:0]   vpfs_in;
  logic [NW*3-1:0] cnts_in;
  logic [M*11-1:0] adr_out;
  logic [M*3-1:0]  cnt_out;
  logic [M-1:0]    vpf_out;
  logic            frame_valid;
  logic            overflow;
  logic            busy;
  logic            dropped;
`ifdef FIRST_N_OVERFLOW_COUNTER_EN
  logic [15:0]     overflow_count;
`endif

  int checks = 0;
  int failures = 0;

  first_n_of_m dut (
    .clock4x       (clock4x),
`ifdef FIRST_N_OVERFLOW_COUNTER_EN
    .overflow_count(overflow_count),
`endif
    .global_reset  (global_reset),
    .latch_in      (latch_in),
    .latch_delay   (latch_delay),
    .vpfs_in       (vpfs_in),
    .cnts_in       (cnts_in),
    .adr_out       (adr_out),
    .cnt_out       (cnt_out),
    .vpf_out       (vpf_out),
    .frame_valid   (frame_valid),
    .overflow      (overflow),
    .busy          (busy),
    .dropped       (dropped)
  );

  always #5 clock4x = ~clock4x;

  task automatic tick();
    @(posedge clock4x);
    #1;
  endtask

  task automatic set_strip(input int s, input int c);
    vpfs_in[s] = 1'b1;
    cnts_in[s*3 +: 3] = 3'(c);
  endtask

  task automatic fire(input int budget, output int lat,
                      output int fv_n, output int drop_n);
    lat = -1;
    fv_n = 0;
    drop_n = 0;
    latch_in = 1'b1;
    tick();
    latch_in = 1'b0;
    for (int e = 1; e <= budget; e++) begin
      tick();
      if (dropped) drop_n++;
      if (frame_valid) begin
        fv_n++;
        if (lat < 0) lat = e;
      end
    end
  endtask

  task automatic test_reset();
    global_reset = 1'b1;
    tick();
    tick();
    global_reset = 1'b0;
    checks++;
    if (adr_out !== {M{11'h7FF}}) begin
      failures++;
      $display("FAIL reset_adr got=%h exp=all ones", adr_out);
    end
    checks++;
    if ({vpf_out, cnt_out, frame_valid, overflow, busy, dropped} !== '0) begin
      failures++;
      $display("FAIL reset_ctl vpf=%b cnt=%h fv=%b ovf=%b busy=%b drop=%b",
               vpf_out, cnt_out, frame_valid, overflow, busy, dropped);
    end
`ifdef FIRST_N_OVERFLOW_COUNTER_EN
    checks++;
    if (overflow_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_ovf_cnt got=%0d exp=0", overflow_count);
    end
`endif
  endtask

  task automatic test_basic();
    int lat, fv, dr;
    int ea [4] = '{3, 700, 768, 1535};
    int ec [4] = '{1, 2, 3, 7};
    vpfs_in = '0;
    cnts_in = '0;
    for (int i = 0; i < 4; i++) set_strip(ea[i], ec[i]);
    fire(40, lat, fv, dr);
    checks++;
    if (lat !== 26 || fv !== 1) begin
      failures++;
      $display("FAIL basic_latency got=%0d pulses=%0d exp=26 pulses=1", lat, fv);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (adr_out[k*11 +: 11] !== 11'(ea[k]) ||
          cnt_out[k*3 +: 3] !== 3'(ec[k]) || vpf_out[k] !== 1'b1) begin
        failures++;
        $display("FAIL basic_slot%0d got=(%0d,%0d,%b) exp=(%0d,%0d,1)", k,
                 adr_out[k*11 +: 11], cnt_out[k*3 +: 3], vpf_out[k],
                 ea[k], ec[k]);
      end
    end
    for (int k = 4; k < M; k++) begin
      checks++;
      if (adr_out[k*11 +: 11] !== 11'd2047 || vpf_out[k] !== 1'b0 ||
          cnt_out[k*3 +: 3] !== 3'd0) begin
        failures++;
        $display("FAIL basic_empty%0d got=(%0d,%0d,%b) exp=(2047,0,0)", k,
                 adr_out[k*11 +: 11], cnt_out[k*3 +: 3], vpf_out[k]);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL basic_overflow got=%b exp=0", overflow);
    end
  endtask

  task automatic test_overflow_single();
    int lat, fv, dr;
    vpfs_in = '0;
    cnts_in = '0;
    for (int i = 0; i < 10; i++) set_strip(i, i % 8);
    fire(40, lat, fv, dr);
    checks++;
    if (lat !== 26) begin
      failures++;
      $display("FAIL ovf1_latency got=%0d exp=26", lat);
    end
    for (int k = 0; k < M; k++) begin
      checks++;
      if (adr_out[k*11 +: 11] !== 11'(k) || vpf_out[k] !== 1'b1 ||
          cnt_out[k*3 +: 3] !== 3'(k)) begin
        failures++;
        $display("FAIL ovf1_slot%0d got=(%0d,%0d,%b) exp=(%0d,%0d,1)", k,
                 adr_out[k*11 +: 11], cnt_out[k*3 +: 3], vpf_out[k], k, k);
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf1_flag got=%b exp=1", overflow);
    end
`ifdef FIRST_N_OVERFLOW_COUNTER_EN
    checks++;
    if (overflow_count !== 16'd1) begin
      failures++;
      $display("FAIL ovf1_count got=%0d exp=1", overflow_count);
    end
`endif
  endtask

  task automatic test_overflow_split();
    int lat, fv, dr;
    int ea [M] = '{10, 20, 30, 40, 50, 768, 769, 770};
    vpfs_in = '0;
    cnts_in = '0;
    for (int i = 0; i < 5; i++) set_strip(10 * (i + 1), 5);
    for (int i = 0; i < 5; i++) set_strip(768 + i, 6);
    fire(40, lat, fv, dr);
    for (int k = 0; k < M; k++) begin
      checks++;
      if (adr_out[k*11 +: 11] !== 11'(ea[k]) || vpf_out[k] !== 1'b1) begin
        failures++;
        $display("FAIL split_slot%0d got=(%0d,%b) exp=(%0d,1)", k,
                 adr_out[k*11 +: 11], vpf_out[k], ea[k]);
      end
    end
    checks++;
    if (overflow !== 1'b1 || lat !== 26) begin
      failures++;
      $display("FAIL split_ovf got=%b lat=%0d exp=1 lat=26", overflow, lat);
    end
  endtask

  task automatic test_drop();
    int fv = 0, dr = 0, lat = -1;
    vpfs_in = '0;
    cnts_in = '0;
    set_strip(5, 4);
    set_strip(1000, 6);
    latch_in = 1'b1;
    tick();
    latch_in = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      latch_in = (e == 10);
      if (e == 3) vpfs_in = '1;
      tick();
      if (dropped) dr++;
      if (frame_valid) begin
        fv++;
        if (lat < 0) lat = e;
      end
    end
    latch_in = 1'b0;
    checks++;
    if (dr !== 1 || fv !== 1 || lat !== 26) begin
      failures++;
      $display("FAIL drop_pulses dropped=%0d fv=%0d lat=%0d exp=1,1,26",
               dr, fv, lat);
    end
    checks++;
    if (adr_out[10:0] !== 11'd5 || adr_out[21:11] !== 11'd1000 ||
        cnt_out[5:0] !== {3'd6, 3'd4} || vpf_out !== 8'b0000_0011) begin
      failures++;
      $display("FAIL drop_frame adr0=%0d adr1=%0d cnt=%h vpf=%b exp=5,1000,34,03",
               adr_out[10:0], adr_out[21:11], cnt_out[5:0], vpf_out);
    end
  endtask

  task automatic test_reset_mid();
    int fv = 0, lat, fv2, dr;
    vpfs_in = '0;
    cnts_in = '0;
    set_strip(100, 2);
    latch_in = 1'b1;
    tick();
    latch_in = 1'b0;
    for (int e = 1; e <= 12; e++) tick();
    global_reset = 1'b1;
    tick();
    global_reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || adr_out !== {M{11'h7FF}} || vpf_out !== '0 ||
        overflow !== 1'b0 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state busy=%b vpf=%b ovf=%b fv=%b exp=0,0,0,0",
               busy, vpf_out, overflow, frame_valid);
    end
`ifdef FIRST_N_OVERFLOW_COUNTER_EN
    checks++;
    if (overflow_count !== 16'd0) begin
      failures++;
      $display("FAIL midreset_count got=%0d exp=0", overflow_count);
    end
`endif
    for (int e = 0; e < 40; e++) begin
      tick();
      if (frame_valid) fv++;
    end
    checks++;
    if (fv !== 0) begin
      failures++;
      $display("FAIL midreset_nofv got=%0d exp=0", fv);
    end
    vpfs_in = '0;
    cnts_in = '0;
    set_strip(1535, 7);
    fire(40, lat, fv2, dr);
    checks++;
    if (lat !== 26 || adr_out[10:0] !== 11'd1535 || cnt_out[2:0] !== 3'd7 ||
        vpf_out !== 8'b0000_0001) begin
      failures++;
      $display("FAIL midreset_refire lat=%0d adr0=%0d cnt0=%0d vpf=%b exp=26,1535,7,01",
               lat, adr_out[10:0], cnt_out[2:0], vpf_out);
    end
  endtask

  task automatic test_latch_delay();
    int lat, fv, dr;
    vpfs_in = '0;
    cnts_in = '0;
    latch_delay = 4'd15;
    fire(70, lat, fv, dr);
    latch_delay = 4'd0;
    checks++;
    if (lat !== 41 || fv !== 1) begin
      failures++;
      $display("FAIL delay_latency got=%0d pulses=%0d exp=41 pulses=1", lat, fv);
    end
    checks++;
    if (vpf_out !== '0 || overflow !== 1'b0 || adr_out !== {M{11'h7FF}}) begin
      failures++;
      $display("FAIL delay_empty vpf=%b ovf=%b adr=%h exp=0,0,all ones",
               vpf_out, overflow, adr_out);
    end
  endtask

  initial begin
    global_reset = 1'b1;
    latch_in = 1'b0;
    latch_delay = 4'd0;
    vpfs_in = '0;
    cnts_in = '0;
    test_reset();
    test_basic();
    test_overflow_single();
    test_overflow_split();
    test_drop();
    test_reset_mid();
    test_latch_delay();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/first_n_of_m.md
Name: first_n_of_m

Overview:
- Parametrised, frame-based cluster selector for the GEM cluster packer.
- Splits NUM_PARTS*PART_WIDTH valid-pattern flags into partitions and iteratively priority-encodes each partition.
- Compacts the per-partition results, in partition order, into the first MAX_CLUSTERS clusters of the frame.
- Sits between the cluster-finding logic (vpfs/cnts) and the packet formatter; it generalises the fixed 8-of-1536 selector in width, partition count, output depth and latch handling, and adds overflow/drop reporting.

Parameters:
- NUM_PARTS, 2, number of independent encoder partitions.
- PART_WIDTH, 768, strips per partition.
- MAX_CLUSTERS, 8, output slots per frame, and per-partition encode depth.
- CNT_BITS, 3, cluster size field width.
- ADR_BITS, 11, address width; must satisfy 2^ADR_BITS-1 >= NUM_PARTS*PART_WIDTH.

Ports:
- clock4x  in  1  single 160 MHz clock.
- global_reset  in  1  synchronous, active-high reset.
- latch_in  in  1  frame strobe.
- latch_delay  in  4  extra cycles between latch_in and capture (0..15).
- vpfs_in  in  NUM_PARTS*PART_WIDTH  cluster-present flags; bit i = strip i.
- cnts_in  in  NUM_PARTS*PART_WIDTH*CNT_BITS  size of the cluster at strip i, in bits [i*CNT_BITS +: CNT_BITS].
- adr_out  out  MAX_CLUSTERS*ADR_BITS  slot k at [k*ADR_BITS +: ADR_BITS].
- cnt_out  out  MAX_CLUSTERS*CNT_BITS  slot k sizes.
- vpf_out  out  MAX_CLUSTERS  slot k valid.
- frame_valid  out  1  one-cycle pulse when outputs update.
- overflow  out  1  held with the frame; more than MAX_CLUSTERS clusters were present.
- busy  out  1  high whenever the FSM is not IDLE.
- dropped  out  1  one-cycle pulse when a capture request was ignored.

Behaviour:
Reset:
- global_reset (synchronous) forces IDLE and clears the latch delay line.
- Resets adr_out to all ones (INVALID_ADR = 2^ADR_BITS-1).
- Resets cnt_out, vpf_out, frame_valid, overflow, busy and dropped to 0.
- Reset mid-frame abandons the frame; no frame_valid is issued.

Latch:
- A 16-deep shift register delays latch_in.
- latch_dly equals latch_in delayed by latch_delay+1 cycles.
- latch_delay is sampled continuously.

Frame timing (FSM IDLE -> ENCODE -> MERGE -> DONE -> IDLE):
- IDLE: on latch_dly at edge k, register vpfs_in and cnts_in into working copies; go to ENCODE.
- ENCODE: edges k+1..k+MAX_CLUSTERS. At each edge, every partition p independently:
  - finds the lowest set bit j of its working vector;
  - appends {adr = p*PART_WIDTH + j, cnt, valid = 1} to its list (depth MAX_CLUSTERS);
  - clears bit j.
  - An empty vector appends an invalid entry.
- Residual check: after the last ENCODE edge, any partition with a nonzero residual vector sets ovf_pending.
- MERGE: NUM_PARTS*MAX_CLUSTERS edges, one candidate per edge.
  - Candidates are scanned in order partition 0 list 0..M-1, then partition 1, and so on.
  - A valid candidate is written to the next free slot if one remains.
  - A valid candidate with no free slot sets ovf_pending.
  - Invalid candidates are skipped without consuming a slot.
- DONE: at one edge, publish adr_out, cnt_out, vpf_out and overflow (= ovf_pending), and pulse frame_valid; return to IDLE.
  - Unfilled slots: adr = INVALID_ADR, cnt = 0, vpf = 0.
- Fixed latency: frame_valid rises at edge k + MAX_CLUSTERS + NUM_PARTS*MAX_CLUSTERS + 1.
  - With defaults this is k+25, independent of occupancy.
- Outputs hold their values until the next DONE or reset.

Ordering:
- Slot order equals ascending strip address, because partitions are scanned in order and each list is ascending.

Capture conflicts:
- latch_dly while not IDLE: request ignored; dropped pulses the following cycle; the current frame is unaffected.
- latch_dly in the same cycle as DONE is also dropped; capture is only accepted in IDLE.

Boundaries:
- Strip 0 yields adr 0.
- The last strip yields adr NUM_PARTS*PART_WIDTH-1.
- An all-zero frame yields all slots invalid, frame_valid still pulses, overflow = 0.

Optional Feature:
- Macro: FIRST_N_OVERFLOW_COUNTER_EN.
- Defined: adds output overflow_count [15:0]. It increments by 1 at each DONE where overflow = 1, saturates at 16'hFFFF, and is cleared by global_reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package cluster_pkg holds:
  - INVALID_ADR function of ADR_BITS;
  - a cluster_t typedef {valid, adr, cnt};
  - FSM state enum {IDLE, ENCODE, MERGE, DONE};
  - latch delay depth 16.
- Sub-module iter_encoder (one per partition): working vector, lowest-set-bit finder, clear logic and list, parametrised by PART_WIDTH, MAX_CLUSTERS, base address.

Test Plan:
- Default params, latch_delay=0: vpfs bits {3, 700, 768, 1535} with cnts {1,2,3,7}, latch_in at cycle 0 -> capture at cycle 1; frame_valid at cycle 26; slots 0..3 = (3,1), (700,2), (768,3), (1535,7); slots 4..7 adr=2047, vpf=0; overflow=0.
- 10 clusters in partition 0 (bits 0..9) -> slots hold adr 0..7; overflow=1. With FIRST_N_OVERFLOW_COUNTER_EN defined, overflow_count=1.
- 5 clusters in partition 0 and 5 in partition 1 (768..772) -> slots = 5 addresses from partition 0 followed by 768, 769, 770; overflow=1.
- latch_in again at cycle 10 of a frame -> dropped pulses once; first frame output unchanged; no second frame_valid.
- global_reset asserted at cycle 12 of a frame -> next edge busy=0 and outputs at reset values; no frame_valid afterwards; a new latch is accepted normally.
- latch_delay=15 with an all-zero frame -> frame_valid exactly 15 cycles later than with latch_delay=0; all vpf_out=0; overflow=0.
